// File: rtl/icache_dm.sv
// Direct-mapped, read-only instruction cache with same-cycle hits and an
// in-order block fill over the iREN/iwait memory handshake.
module icache_dm #(
    parameter int SETS        = 16,
    parameter int BLOCK_WORDS = 2,
    parameter int CNT_W       = 32
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic             imemREN,
    input  logic [31:0]      imemaddr,
    input  logic             iinv,
    output logic             ihit,
    output logic [31:0]      imemload,
    output logic             iREN,
    output logic [31:0]      iaddr,
    input  logic             iwait,
    input  logic [31:0]      iload,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int OFF_W = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 0;
    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 30 - OFF_W - IDX_W;
    localparam int K_W   = (OFF_W > 0) ? OFF_W : 1;
    localparam logic [K_W-1:0] K_LAST     = K_W'(BLOCK_WORDS - 1);
    localparam logic [31:0]    BLOCK_MASK = ~((32'd1 << (2 + OFF_W)) - 32'd1);

    typedef enum logic {IDLE, FILL} state_t;

    state_t             state_reg;
    logic [TAG_W-1:0]   req_tag_reg;
    logic [IDX_W-1:0]   req_idx_reg;
    logic [K_W-1:0]     k_reg;
    logic               iren_reg;
    logic [31:0]        iaddr_reg;
    logic [CNT_W-1:0]   hit_count_reg;
    logic [CNT_W-1:0]   miss_count_reg;

    logic [SETS-1:0]    valid_reg;
    logic [SETS-1:0]    valid_next;
    logic [TAG_W-1:0]   tag_reg  [SETS];
    logic [31:0]        data_reg [SETS][BLOCK_WORDS];

    logic [TAG_W-1:0]   addr_tag;
    logic [IDX_W-1:0]   addr_idx;
    logic [K_W-1:0]     addr_off;
    logic               lookup_hit;
    logic               miss_start;
    logic               word_accept;
    logic               fill_done;
    logic               unused_addr_bits;

    assign addr_tag = imemaddr[31 -: TAG_W];
    assign addr_idx = imemaddr[2 + OFF_W +: IDX_W];
    assign unused_addr_bits = ^imemaddr[1:0];

    generate
        if (OFF_W > 0) begin : g_off
            assign addr_off = imemaddr[2 +: K_W];
        end else begin : g_no_off
            assign addr_off = '0;
        end
    endgenerate

    // iinv masks both the hit and the miss start in the same cycle.
    assign lookup_hit  = (state_reg == IDLE) && imemREN && !iinv &&
                         valid_reg[addr_idx] && (tag_reg[addr_idx] == addr_tag);
    assign miss_start  = (state_reg == IDLE) && imemREN && !iinv && !lookup_hit;
    assign word_accept = (state_reg == FILL) && !iinv && !iwait;
    assign fill_done   = word_accept && (k_reg == K_LAST);

    assign ihit       = lookup_hit;
    assign imemload   = data_reg[addr_idx][addr_off];
    assign iREN       = iren_reg;
    assign iaddr      = iaddr_reg;
    assign hit_count  = hit_count_reg;
    assign miss_count = miss_count_reg;

    // A line is invalidated as soon as its fill starts so a partial block never hits.
    genvar gi;
    generate
        for (gi = 0; gi < SETS; gi++) begin : g_valid
            assign valid_next[gi] =
                iinv                                          ? 1'b0 :
                (miss_start && (addr_idx == IDX_W'(gi)))      ? 1'b0 :
                (fill_done  && (req_idx_reg == IDX_W'(gi)))   ? 1'b1 :
                                                                valid_reg[gi];
        end
    endgenerate

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg   <= IDLE;
            req_tag_reg <= '0;
            req_idx_reg <= '0;
            k_reg       <= '0;
            iren_reg    <= 1'b0;
            iaddr_reg   <= '0;
            valid_reg   <= '0;
        end else begin
            valid_reg <= valid_next;
            case (state_reg)
                IDLE: begin
                    if (miss_start) begin
                        state_reg   <= FILL;
                        req_tag_reg <= addr_tag;
                        req_idx_reg <= addr_idx;
                        k_reg       <= '0;
                        iren_reg    <= 1'b1;
                        iaddr_reg   <= imemaddr & BLOCK_MASK;
                    end
                end
                FILL: begin
                    if (iinv) begin
                        state_reg <= IDLE;
                        iren_reg  <= 1'b0;
                        iaddr_reg <= '0;
                    end else if (!iwait) begin
                        if (k_reg == K_LAST) begin
                            state_reg <= IDLE;
                            iren_reg  <= 1'b0;
                            iaddr_reg <= '0;
                        end else begin
                            k_reg     <= k_reg + K_W'(1);
                            iaddr_reg <= iaddr_reg + 32'd4;
                        end
                    end
                end
            endcase
        end
    end

    // Data and tag contents need no reset; valid bits guard them.
    always_ff @(posedge CLK) begin
        if (nRST && word_accept) begin
            data_reg[req_idx_reg][k_reg] <= iload;
            if (k_reg == K_LAST) begin
                tag_reg[req_idx_reg] <= req_tag_reg;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            hit_count_reg  <= '0;
            miss_count_reg <= '0;
        end else begin
            if (lookup_hit && (hit_count_reg != '1)) begin
                hit_count_reg <= hit_count_reg + CNT_W'(1);
            end
            if (miss_start && (miss_count_reg != '1)) begin
                miss_count_reg <= miss_count_reg + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_icache_dm.sv
// Randomised scoreboard bench for icache_dm: a set/tag map model predicts
// hits, fill addresses, returned words and counter values.
module tb_icache_dm;

    localparam int SETS = 16;
    localparam int BW   = 2;
    localparam int OFFW = $clog2(BW);
    localparam int IDXW = $clog2(SETS);
    localparam logic [31:0] BMASK = ~(32'(BW * 4) - 32'd1);

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        iinv;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;

    logic        s_ihit;
    logic [31:0] s_imemload;
    logic        s_iREN;
    logic [31:0] s_iaddr;
    logic [3:0]  s_hit_count;
    logic [3:0]  s_miss_count;

    icache_dm #(.SETS(SETS), .BLOCK_WORDS(BW), .CNT_W(32)) dut (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iinv(iinv),
        .ihit(ihit), .imemload(imemload), .iREN(iREN), .iaddr(iaddr),
        .iwait(iwait), .iload(iload), .hit_count(hit_count), .miss_count(miss_count)
    );

    icache_dm #(.SETS(SETS), .BLOCK_WORDS(BW), .CNT_W(4)) dut_sat (
        .CLK(CLK), .nRST(nRST), .imemREN(imemREN), .imemaddr(imemaddr), .iinv(iinv),
        .ihit(s_ihit), .imemload(s_imemload), .iREN(s_iREN), .iaddr(s_iaddr),
        .iwait(iwait), .iload(iload), .hit_count(s_hit_count), .miss_count(s_miss_count)
    );

    int errors = 0;
    int checks = 0;

    logic [31:0] exp_data_q[$];
    logic [31:0] exp_addr_q[$];

    bit          mv [SETS];
    logic [31:0] mt [SETS];
    int          m_hit  = 0;
    int          m_miss = 0;
    int          lat_fixed = 2;

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0000_0100) return 32'hAAAA_0001;
        if (a == 32'h0000_0104) return 32'hAAAA_0002;
        return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic check_counters();
        check("hit_count", hit_count, 32'(m_hit));
        check("miss_count", miss_count, 32'(m_miss));
        check("sat_hit_count", {28'd0, s_hit_count}, 32'(sat15(m_hit)));
        check("sat_miss_count", {28'd0, s_miss_count}, 32'(sat15(m_miss)));
    endtask

    task automatic model_clear();
        for (int s = 0; s < SETS; s++) mv[s] = 1'b0;
    endtask

    // Memory: each accepted word costs cur_lat busy cycles then one ready cycle.
    initial begin
        int cnt;
        int cur_lat;
        cnt = 0;
        cur_lat = 2;
        iwait = 1'b1;
        iload = 32'h0;
        forever begin
            @(posedge CLK);
            #1;
            if (!iREN) begin
                iwait = 1'b1;
                iload = $urandom;
                cnt = 0;
                cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end else if (cnt < cur_lat) begin
                iwait = 1'b1;
                iload = $urandom;
                cnt++;
            end else begin
                iwait = 1'b0;
                iload = mem_word(iaddr);
                cnt = 0;
                cur_lat = (lat_fixed >= 0) ? lat_fixed : int'($urandom_range(0, 3));
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a hit or a memory beat.
    always @(negedge CLK) begin
        if (nRST) begin
            if (ihit) begin
                if (exp_data_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_hit: got addr %h data %h expected no hit", imemaddr, imemload);
                end else begin
                    check("hit_data", imemload, exp_data_q.pop_front());
                end
            end
            if (iREN && !iwait) begin
                if (exp_addr_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read: got iaddr %h expected no read", iaddr);
                end else begin
                    check("fill_addr", iaddr, exp_addr_q.pop_front());
                end
            end
            if (!iREN && (iaddr != 32'h0)) begin
                checks++; errors++;
                $display("FAIL idle_iaddr: got %h expected 00000000", iaddr);
            end
        end
    end

    task automatic fetch(input logic [31:0] a, input bit inv_first, output int lat);
        int idx;
        int n;
        logic [31:0] tag;
        logic [31:0] base;
        if (inv_first) model_clear();
        idx  = int'((a >> (2 + OFFW)) & 32'(SETS - 1));
        tag  = a >> (2 + OFFW + IDXW);
        base = a & BMASK;
        if (!(mv[idx] && (mt[idx] == tag))) begin
            for (int w = 0; w < BW; w++) exp_addr_q.push_back(base + 32'(4 * w));
            mv[idx] = 1'b1;
            mt[idx] = tag;
            m_miss++;
        end
        exp_data_q.push_back(mem_word({a[31:2], 2'b00}));
        m_hit++;
        imemREN  = 1'b1;
        imemaddr = a;
        iinv     = inv_first;
        n = 0;
        forever begin
            @(negedge CLK);
            n++;
            if (n == 1 && inv_first) begin
                check("inv_blocks_hit", {31'd0, ihit}, 32'd0);
                @(posedge CLK);
                #1 iinv = 1'b0;
                continue;
            end
            if (ihit) break;
            if (n > 200) begin
                checks++; errors++;
                $display("FAIL fetch_timeout: got no hit for %h expected hit", a);
                break;
            end
        end
        lat = n - 1;
        @(posedge CLK);
        #1 imemREN = 1'b0;
    endtask

    task automatic wait_accept();
        int n;
        n = 0;
        forever begin
            @(negedge CLK);
            if (iREN && !iwait) break;
            n++;
            if (n > 100) begin
                checks++; errors++;
                $display("FAIL accept_timeout: got no memory beat expected one");
                break;
            end
        end
    endtask

    initial begin
        int lat;
        logic [31:0] a;
        nRST = 1'b0; imemREN = 1'b0; imemaddr = 32'h0; iinv = 1'b0;
        model_clear();

        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check("rst_ihit", {31'd0, ihit}, 32'd0);
        check("rst_iREN", {31'd0, iREN}, 32'd0);
        check("rst_iaddr", iaddr, 32'd0);
        check_counters();
        @(posedge CLK);
        #1 nRST = 1'b1;

        fetch(32'h0000_0104, 1'b0, lat);
        check("cold_miss_latency", 32'(lat), 32'd7);
        check_counters();

        fetch(32'h0000_0100, 1'b0, lat);
        check("spatial_hit_latency", 32'(lat), 32'd0);
        check_counters();

        fetch(32'h0000_0184, 1'b0, lat);
        check("conflict_latency", 32'(lat), 32'd7);
        fetch(32'h0000_0104, 1'b0, lat);
        check("evicted_refetch_latency", 32'(lat), 32'd7);
        check("miss_count_three", miss_count, 32'd3);
        check_counters();

        // Invalidate one cycle after the first word of a fill.
        a = 32'h0000_2010;
        exp_addr_q.push_back(a & BMASK);
        m_miss++;
        imemREN = 1'b1; imemaddr = a;
        wait_accept();
        @(posedge CLK);
        #1 iinv = 1'b1;
        model_clear();
        @(negedge CLK);
        @(posedge CLK);
        #1 iinv = 1'b0;
        @(negedge CLK);
        check("inv_iren_drop", {31'd0, iREN}, 32'd0);
        check("inv_no_hit", {31'd0, ihit}, 32'd0);
        for (int w = 0; w < BW; w++) exp_addr_q.push_back((a & BMASK) + 32'(4 * w));
        mv[int'((a >> (2 + OFFW)) & 32'(SETS - 1))] = 1'b1;
        mt[int'((a >> (2 + OFFW)) & 32'(SETS - 1))] = a >> (2 + OFFW + IDXW);
        m_miss++;
        exp_data_q.push_back(mem_word(a));
        m_hit++;
        for (int n = 0; n < 200 && !ihit; n++) @(negedge CLK);
        check("inv_refill_hit", {31'd0, ihit}, 32'd1);
        @(posedge CLK);
        #1 imemREN = 1'b0;
        check_counters();

        for (int i = 0; i < 20; i++) fetch(32'h0000_2014, 1'b0, lat);
        check("sat_hit_hold", {28'd0, s_hit_count}, 32'd15);
        check_counters();

        lat_fixed = -1;
        for (int i = 0; i < 300; i++) begin
            a = ($urandom_range(0, 3) << 7) | ($urandom_range(0, 3) << 3) |
                ($urandom_range(0, 1) << 2) | $urandom_range(0, 3);
            fetch(a, ($urandom_range(0, 9) == 0), lat);
            if ($urandom_range(0, 19) == 0) begin
                iinv = 1'b1;
                model_clear();
                @(posedge CLK);
                #1 iinv = 1'b0;
            end
            if (i % 50 == 49) check_counters();
        end

        // Reset in the middle of a fill.
        lat_fixed = 2;
        a = 32'h0000_3000;
        exp_addr_q.push_back(a & BMASK);
        imemREN = 1'b1; imemaddr = a;
        wait_accept();
        @(posedge CLK);
        #1 nRST = 1'b0; imemREN = 1'b0;
        @(posedge CLK);
        #1 nRST = 1'b1;
        check("midrst_iREN", {31'd0, iREN}, 32'd0);
        check("midrst_iaddr", iaddr, 32'd0);
        model_clear();
        m_hit = 0; m_miss = 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        check_counters();
        fetch(a, 1'b0, lat);
        check("post_rst_latency", 32'(lat), 32'd7);
        check_counters();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Parametrised, direct-mapped, read-only instruction cache that sits between the datapath instruction port and the memory-side instruction port of the caches wrapper.
- Successor to the single-cycle passthrough. Adds tag/valid storage, multi-word blocks, a miss-fill state machine over the iwait handshake, whole-cache invalidate and hit/miss performance counters.
- Hits return in the same cycle. A miss stalls the datapath until the block is filled.

Parameters:
- SETS, 16, number of blocks; power of 2, at least 2.
- BLOCK_WORDS, 2, 32-bit words per block; power of 2, at least 1.
- CNT_W, 32, width of the hit/miss performance counters.

Ports:
- CLK  in  1  clock. Reset is nRST: synchronous, active-low; clock is CLK.
- nRST  in  1  synchronous active-low reset.
- imemREN  in  1  datapath instruction read request.
- imemaddr  in  32  datapath byte address; bits [1:0] ignored.
- iinv  in  1  invalidate all lines; single-cycle pulse.
- ihit  out  1  requested word valid this cycle.
- imemload  out  32  instruction word.
- iREN  out  1  memory read request.
- iaddr  out  32  memory byte address.
- iwait  in  1  memory busy; data is valid on iload when iREN=1 and iwait=0.
- iload  in  32  memory read data.
- hit_count  out  CNT_W  saturating hit counter.
- miss_count  out  CNT_W  saturating miss counter.

Behaviour:
- Address split:
  - OFF_W = log2(BLOCK_WORDS); OFF_W = 0 when BLOCK_WORDS = 1.
  - IDX_W = log2(SETS).
  - Offset = imemaddr[2+OFF_W-1:2].
  - Index = the next IDX_W bits.
  - Tag = the remaining upper bits, TAG_W = 30-OFF_W-IDX_W.
- Storage: per set, one valid bit, one tag and BLOCK_WORDS data words. Data and tag storage are flops.
- FSM states are IDLE and FILL. Reset state is IDLE.
- IDLE:
  - ihit = imemREN & valid[idx] & (tag[idx]==req_tag).
  - imemload = data[idx][off] (combinational read).
  - On imemREN & !hit & !iinv: latch req_tag and req_idx, clear fill counter k to 0, go to FILL, and increment miss_count once.
- FILL:
  - ihit = 0; iREN = 1; iaddr = {req_tag, req_idx, k, 2'b00}. Words are filled in order from 0 to BLOCK_WORDS-1; there is no critical-word-first.
  - Each cycle with iwait=0: write iload into data[req_idx][k] and increment k.
  - On the last word: set valid[req_idx], write tag[req_idx]=req_tag, and return to IDLE. The hit is observed the following cycle, so miss latency is BLOCK_WORDS × (mem latency) + 1 cycles.
  - valid[req_idx] is cleared on FILL entry, so a partially filled line never hits.
  - Changes to imemREN or imemaddr during FILL are ignored. The fill always completes (unless iinv arrives) and the request is re-evaluated in IDLE.
- Outputs outside FILL: iREN = 0 and iaddr = 0. imemload is undefined-but-stable when ihit = 0; drive the indexed word.
- iinv:
  - Clears every valid bit at the clock edge.
  - In FILL it aborts the fill: go to IDLE, iREN drops the next cycle, and no valid/tag update occurs.
  - ihit is forced to 0 in the iinv cycle.
  - If iinv and a miss start coincide, iinv wins and miss_count does not increment.
- Counters:
  - hit_count increments every cycle ihit=1.
  - Both counters saturate at all-ones; there is no wrap.
- Reset (nRST=0 at an edge):
  - All valids 0, state IDLE, k = 0, both counters 0.
  - Outputs next cycle: ihit 0, iREN 0, iaddr 0.
  - Reset mid-fill abandons the fill immediately. Data array contents are don't-care.
- Conflict: a fill overwrites the set regardless of its prior valid or tag. There is no write path, so no write-back is needed.

Test Plan:
- Reset then idle: nRST low 2 cycles, imemREN=0 → ihit=0, iREN=0, iaddr=0, counters 0.
- Cold miss (SETS=16, BLOCK_WORDS=2, iwait high 2 cycles per word), imemaddr=0x0000_0104:
  - iaddr=0x100 then 0x104, iload 0xAAAA0001 / 0xAAAA0002.
  - ihit=1 with imemload=0xAAAA0002 exactly 1 cycle after the second iwait=0.
  - miss_count=1.
- Spatial hit: after the above, imemaddr=0x100 → same-cycle ihit=1, imemload=0xAAAA0001, hit_count increments, iREN stays 0.
- Conflict eviction: access 0x0000_0184, which has the same index with a different tag → miss, refill from 0x180/0x184. A re-access of 0x104 then misses again, giving miss_count=3.
- iinv mid-fill: pulse iinv after the first word of a fill → iREN=0 next cycle, the line does not hit, and re-request refetches from word 0.
- Saturation (CNT_W=4): 20 consecutive hits → hit_count holds at 15.
